irq_pending_arbiter: RTL and testbench
======================================

# irq_pending_arbiter

Edge-triggered interrupt front end for the 8-input priority-encoding path. It captures rising edges on eight request lines into a sticky pending register and applies a mask. It selects the highest-index unmasked pending line using the same priority order as the 8-to-3 priority encoder, bit 7 highest. It presents the winner as a registered 3-bit ID over a valid/ack handshake to the downstream consumer.

## Interface
- No parameters; width fixed at 8 requests / 3-bit ID.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_in  in  8  request lines, synchronous to clk; an event is a 0->1 transition between consecutive samples.
- mask  in  8  1 = line blocked from arbitration (still latched into pending).
- irq_ack  in  1  consumer accepts current grant.
- irq_valid  out  1  grant presented.
- irq_id  out  3  index of granted line; stable while irq_valid=1.
- pending  out  8  pending register (registered).
- overrun  out  1  sticky: an event arrived on a line already pending; cleared only by reset.

## Operation
- Edge detect:
  - req_q <= req_in each cycle.
  - rise = req_in & ~req_q.
  - req_q resets to 0, so a line already high when reset is released counts as one event.
- Pending update, per cycle: pending <= (pending & ~clr) | rise.
  - clr is a one-hot of irq_id when an ack is accepted, else 0.
  - Set wins over clear on the same bit in the same cycle (re-pend).
- Overrun: set when (rise & pending & ~clr) != 0.
- Eligible = pending & ~mask.
- Winner = index of the highest set bit of eligible.
- FSM states:
  - IDLE:
    - irq_valid=0.
    - If eligible != 0: irq_id <= winner, irq_valid <= 1, go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT:
    - irq_valid=1; irq_id is held.
    - mask and pending changes do not alter irq_id, even if the granted line becomes masked.
    - On irq_ack=1: clear pending[irq_id], irq_valid <= 0, go to IDLE.
- irq_ack while in IDLE is ignored.
- After an ack there is always exactly one IDLE cycle before the next grant. This gives one gap cycle between back-to-back grants.
- Arbitration uses the registered pending and mask values sampled in the IDLE cycle.

## Timing
- Reset values: req_q=0, pending=0, overrun=0, irq_valid=0, irq_id=0, FSM=IDLE.
- Reset asserted mid-operation:
  - Everything returns to reset values on the next edge.
  - Any outstanding grant is dropped without requiring an ack.
- Latency from req_in sampled high at edge k (with req_q=0), line unmasked, FSM in IDLE:
  - pending bit is visible after edge k.
  - irq_valid=1 and irq_id are visible after edge k+1.
  - Total: 2 cycles.
- Ack sampled at edge a:
  - irq_valid=0 and the pending bit cleared after edge a.
  - Earliest next irq_valid=1 is after edge a+1.
- Maximum grant rate: one grant per 2 cycles with continuous ack.
- Simultaneous rises on several lines: all of them latch; grants follow in descending index order.
- A level held high generates exactly one event.

## Test plan
- Reset behaviour:
  - Stimulus: rst_n=0 for 2 cycles with req_in=8'h00.
  - Response: all outputs 0.
  - Stimulus: release reset with req_in=8'h01.
  - Response: irq_valid=1 and irq_id=0 two cycles after release; pending=8'h01 until ack.
- Priority ordering:
  - Stimulus: req_in 8'h00->8'h96 in one cycle, mask=0, ack in every GRANT cycle.
  - Response: irq_id sequence 7,4,2,1; pending ends at 8'h00; overrun=0.
- Masking:
  - Stimulus: mask=8'h80, event on lines 7 and 3.
  - Response: grant 3 only; pending=8'h80 held.
  - Stimulus: then mask=0.
  - Response: grant 7 two cycles later.
- Handshake hold:
  - Stimulus: grant 5 outstanding; hold ack low 10 cycles; raise events on 6 and 7 during that time.
  - Response: irq_id stays 5 throughout; after ack, next grants are 7 then 6.
- Set/clear collision and overrun:
  - Stimulus: grant 2 outstanding; line 2 falls and rises again so its rise lands in the ack cycle.
  - Response: pending[2] stays 1, line 2 is re-granted after the gap cycle, overrun=0.
  - Stimulus: a second rise on line 2 while pending.
  - Response: overrun=1, persisting until reset.
- Reset mid-grant:
  - Stimulus: rst_n=0 for 1 cycle while irq_valid=1 and pending=8'h0C.
  - Response: irq_valid=0, pending=0 on the next edge; no grant afterwards without new events.

Source files
------------

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter
// Edge-triggered interrupt front end: captures rising edges on eight request
// lines into a sticky pending register, masks them, and grants the
// highest-index eligible line (bit 7 highest) as a registered 3-bit ID
// over a valid/ack handshake.
module irq_pending_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_in,
   input  logic [7:0] mask,
   input  logic       irq_ack,
   output logic       irq_valid,
   output logic [2:0] irq_id,
   output logic [7:0] pending,
   output logic       overrun
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_reg;
   logic [7:0] req_q;
   logic [7:0] rise;
   logic [7:0] clr;
   logic [7:0] eligible;
   logic       ack_accept;
   logic [2:0] winner;

   assign rise       = req_in & ~req_q;
   assign eligible   = pending & ~mask;
   // An ack only counts while a grant is actually being presented.
   assign ack_accept = (state_reg == GRANT) && irq_ack;

   // One-hot clear of the granted line, active only in the ack cycle.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_clr
         assign clr[gi] = ack_accept && (irq_id == 3'(gi));
      end
   endgenerate

   // Priority encode the eligible set; later iterations win, so bit 7 is highest.
   always_comb begin
      winner = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eligible[i]) begin
            winner = i[2:0];
         end
      end
   end

   // Edge capture, pending set/clear (set wins) and the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q   <= 8'h00;
         pending <= 8'h00;
         overrun <= 1'b0;
      end else begin
         req_q   <= req_in;
         pending <= (pending & ~clr) | rise;
         if ((rise & pending & ~clr) != 8'h00) begin
            overrun <= 1'b1;
         end
      end
   end

   // Grant FSM: latch a winner from IDLE, hold it in GRANT until acked.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         irq_valid <= 1'b0;
         irq_id    <= 3'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (eligible != 8'h00) begin
                  irq_id    <= winner;
                  irq_valid <= 1'b1;
                  state_reg <= GRANT;
               end
            end
            GRANT: begin
               // irq_id is deliberately held here regardless of mask/pending.
               if (irq_ack) begin
                  irq_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               irq_valid <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb_irq_pending_arbiter
// Directed bench for irq_pending_arbiter with hand-computed expectations.
module tb_irq_pending_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_in;
   logic [7:0] mask;
   logic       irq_ack;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic       overrun;

   int checks;
   int failures;

   irq_pending_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .mask      (mask),
      .irq_ack   (irq_ack),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .pending   (pending),
      .overrun   (overrun)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [2:0] id,
                          input logic [7:0] p, input logic ov);
      chk({tag, ".valid"},   {7'd0, irq_valid}, {7'd0, v});
      chk({tag, ".id"},      {5'd0, irq_id},    {5'd0, id});
      chk({tag, ".pending"}, pending,           p);
      chk({tag, ".overrun"}, {7'd0, overrun},   {7'd0, ov});
   endtask

   logic [2:0] prio_ids [4];
   logic [7:0] prio_pend [4];

   // Linear directed sequence covering the whole test plan.
   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      req_in   = 8'h00;
      mask     = 8'h00;
      irq_ack  = 1'b0;

      // Reset behaviour.
      tick();
      tick();
      chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

      rst_n  = 1'b1;
      req_in = 8'h01;
      tick();
      chk_all("rel_e1", 1'b0, 3'd0, 8'h01, 1'b0);
      tick();
      chk_all("rel_e2", 1'b1, 3'd0, 8'h01, 1'b0);
      tick();
      chk_all("rel_hold", 1'b1, 3'd0, 8'h01, 1'b0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("rel_ack", 1'b0, 3'd0, 8'h00, 1'b0);
      tick();
      tick();
      chk_all("level_once", 1'b0, 3'd0, 8'h00, 1'b0);

      // Priority ordering: 0x96 -> lines 7,4,2,1.
      req_in = 8'h00;
      tick();
      req_in = 8'h96;
      tick();
      chk("prio_latch", pending, 8'h96);
      tick();
      prio_ids  = '{3'd7, 3'd4, 3'd2, 3'd1};
      prio_pend = '{8'h16, 8'h06, 8'h02, 8'h00};
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("prio_valid%0d", k), {7'd0, irq_valid}, 8'h01);
         chk($sformatf("prio_id%0d", k), {5'd0, irq_id}, {5'd0, prio_ids[k]});
         irq_ack = 1'b1;
         tick();
         irq_ack = 1'b0;
         chk($sformatf("prio_gap%0d", k), {7'd0, irq_valid}, 8'h00);
         chk($sformatf("prio_pend%0d", k), pending, prio_pend[k]);
         tick();
      end
      chk_all("prio_end", 1'b0, 3'd1, 8'h00, 1'b0);

      // Masking: line 7 blocked, line 3 granted.
      req_in = 8'h00;
      tick();
      mask   = 8'h80;
      req_in = 8'h88;
      tick();
      chk("mask_latch", pending, 8'h88);
      tick();
      chk_all("mask_g3", 1'b1, 3'd3, 8'h88, 1'b0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("mask_ack3", 1'b0, 3'd3, 8'h80, 1'b0);
      tick();
      tick();
      chk_all("mask_block", 1'b0, 3'd3, 8'h80, 1'b0);
      mask = 8'h00;
      tick();
      tick();
      chk_all("unmask_g7", 1'b1, 3'd7, 8'h80, 1'b0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("unmask_ack7", 1'b0, 3'd7, 8'h00, 1'b0);

      // Handshake hold: grant 5 stays while 6 and 7 arrive.
      req_in = 8'h00;
      tick();
      req_in = 8'h20;
      tick();
      tick();
      chk_all("hold_g5", 1'b1, 3'd5, 8'h20, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) req_in = 8'hE0;
         tick();
         chk($sformatf("hold_id%0d", k), {5'd0, irq_id}, 8'h05);
         chk($sformatf("hold_v%0d", k), {7'd0, irq_valid}, 8'h01);
      end
      chk("hold_pend", pending, 8'hE0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("hold_ack5", 1'b0, 3'd5, 8'hC0, 1'b0);
      tick();
      chk_all("hold_g7", 1'b1, 3'd7, 8'hC0, 1'b0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("hold_ack7", 1'b0, 3'd7, 8'h40, 1'b0);
      tick();
      chk_all("hold_g6", 1'b1, 3'd6, 8'h40, 1'b0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("hold_ack6", 1'b0, 3'd6, 8'h00, 1'b0);

      // Set/clear collision on line 2 in the ack cycle.
      req_in = 8'h00;
      tick();
      req_in = 8'h04;
      tick();
      tick();
      chk_all("coll_g2", 1'b1, 3'd2, 8'h04, 1'b0);
      req_in = 8'h00;
      tick();
      req_in  = 8'h04;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk_all("coll_ack", 1'b0, 3'd2, 8'h04, 1'b0);
      tick();
      chk_all("coll_regrant", 1'b1, 3'd2, 8'h04, 1'b0);

      // Second rise while pending -> overrun.
      req_in = 8'h00;
      tick();
      req_in = 8'h04;
      tick();
      chk_all("ovr_set", 1'b1, 3'd2, 8'h04, 1'b1);
      tick();
      tick();
      req_in = 8'h0C;
      tick();
      chk_all("ovr_sticky", 1'b1, 3'd2, 8'h0C, 1'b1);

      // Reset mid-grant drops everything.
      rst_n  = 1'b0;
      req_in = 8'h00;
      tick();
      chk_all("rst_mid", 1'b0, 3'd0, 8'h00, 1'b0);
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      chk_all("rst_quiet", 1'b0, 3'd0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
